// File: rtl/serial_xfer_ctrl_pkg.sv
// Shared types and defaults for the serial transfer controller.
// State codes are fixed so the encoding stays stable across revisions.
package serial_xfer_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/serial_bit_cnt.sv
// Loadable bit-index up-counter with a terminal flag at WIDTH-1.
// Shared by the source-side sequencer and the sink-side collector.
module serial_bit_cnt #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          areset_n,
    input  logic          load,
    input  logic [CW-1:0] init,
    input  logic          inc,
    output logic [CW-1:0] cnt,
    output logic          tc
);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= init;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_xfer_ctrl.sv
// Word-to-serial sequencer: clears the serial unit, streams a word
// LSB-first into it and reassembles the unit's output into a word.
module serial_xfer_ctrl
    import serial_xfer_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             unit_clr,
    output logic             unit_x,
    input  logic             unit_z,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] res;
    logic [CW-1:0]    cnt;
    logic             cnt_tc;
    logic             accept;
    logic             cnt_load;
    logic             cnt_inc;

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                cnt_load  = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                cnt_inc = 1'b1;
                if (cnt_tc) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // unit_x leads the capture by one edge so unit_z settles within the cycle
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            sreg     <= '0;
            res      <= '0;
            unit_clr <= 1'b0;
            unit_x   <= 1'b0;
        end else begin
            unit_clr <= accept;
            if (accept) begin
                sreg <= in_data;
            end
            if (state == CLEAR || state == SHIFT) begin
                unit_x <= sreg[0];
                sreg   <= sreg >> 1;
            end
            if (state == SHIFT) begin
                res[cnt] <= unit_z;
            end
        end
    end

    serial_bit_cnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk      (clk),
        .areset_n (areset_n),
        .load     (cnt_load),
        .init     ('0),
        .inc      (cnt_inc),
        .cnt      (cnt),
        .tc       (cnt_tc)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == HOLD);
    assign busy      = (state != IDLE);
    assign out_data  = res;

endmodule

// File: tb/tb_serial_xfer_ctrl.sv
// Bench for serial_xfer_ctrl driving a serial two's-complementer partner.
// Expected words come from arithmetic negation modulo 2^WIDTH.
module tb_serial_xfer_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       iv, ir, ov, ordy, clr, ux, uz, bsy;
    logic [7:0] id, od;
    logic       iv4, ir4, ov4, ordy4, clr4, ux4, uz4, bsy4;
    logic [3:0] id4, od4;

    int n_cmp = 0;
    int n_bad = 0;

    serial_xfer_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .areset_n(rst_n),
        .in_valid(iv), .in_ready(ir), .in_data(id),
        .out_valid(ov), .out_ready(ordy), .out_data(od),
        .unit_clr(clr), .unit_x(ux), .unit_z(uz), .busy(bsy)
    );

    serial_xfer_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .areset_n(rst_n),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4),
        .out_valid(ov4), .out_ready(ordy4), .out_data(od4),
        .unit_clr(clr4), .unit_x(ux4), .unit_z(uz4), .busy(bsy4)
    );

    // serial two's-complementer: pass bits until the first 1, then invert
    logic seen8, seen4;
    wire  ua8 = clr | ~rst_n;
    wire  ua4 = clr4 | ~rst_n;

    always @(posedge clk or posedge ua8)
        if (ua8) seen8 <= 1'b0;
        else if (ux) seen8 <= 1'b1;

    always @(posedge clk or posedge ua4)
        if (ua4) seen4 <= 1'b0;
        else if (ux4) seen4 <= 1'b1;

    assign uz  = seen8 ? ~ux : ux;
    assign uz4 = seen4 ? ~ux4 : ux4;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] neg8(input logic [7:0] d);
        return 8'((256 - int'(d)) % 256);
    endfunction

    task automatic xfer(input logic [7:0] d, input int poke,
                        output logic [7:0] r);
        int         lat;
        int         nclr;
        logic [7:0] xs;
        bit         got;
        bit         bad_ir;
        for (int k = 0; k < 40 && !ir; k++) @(negedge clk);
        chk("in_ready_before", ir, 1);
        iv   = 1'b1;
        id   = d;
        ordy = 1'b1;
        @(negedge clk);
        iv     = 1'b0;
        id     = 8'($urandom);
        lat    = 0;
        nclr   = 0;
        xs     = '0;
        got    = 1'b0;
        bad_ir = 1'b0;
        r      = '0;
        while (lat <= 30) begin
            if (clr) nclr++;
            if (lat >= 1 && lat <= 8) xs[lat-1] = ux;
            if (ov) begin
                got = 1'b1;
                r   = od;
                break;
            end
            if (ir) bad_ir = 1'b1;
            if (lat == poke) begin
                iv = 1'b1;
                id = 8'hFF;
            end else begin
                iv = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        iv = 1'b0;
        chk("got_result", got, 1);
        chk("latency", lat, 9);
        chk("clr_pulses", nclr, 1);
        chk("unit_x_seq", xs, d);
        chk("in_ready_low", bad_ir, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic [7:0] r;
        logic [7:0] d;
        int         lat;
        bit         got;

        vecs[0] = '{8'h01, 8'hFF};
        vecs[1] = '{8'h00, 8'h00};
        vecs[2] = '{8'h80, 8'h80};
        vecs[3] = '{8'h34, 8'hCC};
        vecs[4] = '{8'h7F, 8'h81};
        vecs[5] = '{8'hFF, 8'h01};

        rst_n = 1'b0;
        iv    = 1'b0;
        id    = '0;
        ordy  = 1'b0;
        iv4   = 1'b0;
        id4   = '0;
        ordy4 = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", ir, 1);
        chk("rst_out_valid", ov, 0);
        chk("rst_out_data", od, 0);
        chk("rst_unit_clr", clr, 0);
        chk("rst_unit_x", ux, 0);
        chk("rst_busy", bsy, 0);
        rst_n = 1'b1;
        @(negedge clk);

        xfer(8'h01, -1, r);
        chk("first_h01", r, 8'hFF);

        foreach (vecs[i]) begin
            xfer(vecs[i].din, -1, r);
            chk($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // back-pressure with a competing word offered during HOLD
        for (int k = 0; k < 40 && !ir; k++) @(negedge clk);
        ordy = 1'b0;
        iv   = 1'b1;
        id   = 8'h34;
        @(negedge clk);
        iv  = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (ov) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("bp_reach_hold", got, 1);
        iv = 1'b1;
        id = 8'hAA;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_out_valid", ov, 1);
            chk("bp_out_data", od, 8'hCC);
            chk("bp_in_ready", ir, 0);
        end
        ordy = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", ov, 0);
        chk("bp_release_ready", ir, 1);
        @(negedge clk);
        iv = 1'b0;
        chk("bp_aa_accepted", bsy, 1);
        got = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (ov) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("bp_aa_done", got, 1);
        chk("bp_aa_data", od, neg8(8'hAA));

        // reset while bit 3 is on unit_x
        for (int k = 0; k < 40 && !ir; k++) @(negedge clk);
        iv = 1'b1;
        id = 8'h5A;
        @(negedge clk);
        iv = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_busy", bsy, 1);
        chk("mid_bit3", ux, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_in_ready", ir, 1);
        chk("mid_out_valid", ov, 0);
        chk("mid_out_data", od, 0);
        chk("mid_unit_clr", clr, 0);
        chk("mid_unit_x", ux, 0);
        chk("mid_busy_rst", bsy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        got = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (ov) got = 1'b1;
        end
        chk("mid_no_pulse", got, 0);
        xfer(8'h01, -1, r);
        chk("post_rst_h01", r, 8'hFF);

        xfer(8'h34, 3, r);
        chk("poke_ignored", r, 8'hCC);

        for (int n = 0; n < 20; n++) begin
            d = 8'($urandom);
            xfer(d, -1, r);
            chk($sformatf("rand_%02h", d), r, neg8(d));
        end

        // narrow instance
        iv4 = 1'b1;
        id4 = 4'h6;
        @(negedge clk);
        iv4 = 1'b0;
        lat = 0;
        while (!ov4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("w4_latency", lat, 5);
        chk("w4_data", od4, 4'hA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_xfer_ctrl.md
# serial_xfer_ctrl

Sequencer for the bit-serial Mealy unit (clk / areset / x / z, e.g. the serial two's-complementer). It accepts a parallel word over a valid/ready handshake and clears the serial unit for one cycle. It then streams the word LSB-first into `unit_x`, samples `unit_z` in the same cycle, and returns the reassembled word over a second valid/ready handshake. It sits between the word-level datapath and the serial unit and is the only driver of that unit's inputs.

## Interface
- `WIDTH`, default 8: word width in bits; legal range 2–32.
- `clk`  in  1  rising-edge clock.
- `areset_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  source has a word.
- `in_ready`  out  1  controller can accept; equals (state == IDLE).
- `in_data`  in  WIDTH  word to transform.
- `out_valid`  out  1  result word available.
- `out_ready`  in  1  sink accepts result.
- `out_data`  out  WIDTH  result word; stable while `out_valid` is high.
- `unit_clr`  out  1  active-high clear to the serial unit; registered, glitch-free.
- `unit_x`  out  1  serial bit to the unit; registered.
- `unit_z`  in  1  unit's Mealy output; combinationally dependent on `unit_x`.
- `busy`  out  1  state != IDLE.

## Operation
- States:
  - IDLE: `in_ready`=1. On `in_valid` & `in_ready`, load `in_data` into the shift register `sreg`, then go to CLEAR.
  - CLEAR: `unit_clr`=1 for exactly one cycle. Bit counter `cnt` is set to 0. `unit_x` is loaded with `sreg[0]`. Go to SHIFT.
  - SHIFT: `unit_x` = current bit.
    - Each edge: capture `unit_z` into the result register `res` at bit index `cnt` (shift-in from the MSB side, LSB-first), shift `sreg` right, load the next bit into `unit_x`, and increment `cnt`.
    - After the edge that captures bit WIDTH-1, go to HOLD.
  - HOLD: `out_valid`=1 and `out_data`=`res`. On `out_ready`, go to IDLE.
- `cnt` width is clog2(WIDTH). No wrap inside SHIFT: exit is decoded at `cnt` == WIDTH-1.
- `in_valid` outside IDLE is ignored (`in_ready`=0), and `in_data` is not sampled.
- `out_ready` outside HOLD is ignored.
- Reset values: state=IDLE, `in_ready`=1, `out_valid`=0, `out_data`=0, `unit_clr`=0, `unit_x`=0, `busy`=0, `sreg`=0, `res`=0, `cnt`=0.
- Reset asserted mid-operation (any state): immediate return to reset values. The partial word is discarded and no `out_valid` pulse occurs.
- `unit_clr` is not asserted during reset; the unit has its own reset.

## Timing
- Accept edge E0 (`in_valid` & `in_ready` sampled high).
- Cycle E0→E1: CLEAR, `unit_clr`=1.
- Cycles E1…E(WIDTH): SHIFT. Bit i is on `unit_x` during cycle E(i+1)→E(i+2), and `unit_z` is sampled at edge E(i+2).
- `out_valid` rises after edge E(WIDTH+1), i.e. WIDTH+1 cycles after accept (9 for WIDTH=8).
- With `out_ready` held high, `out_valid` is a 1-cycle pulse. IDLE follows, and the next accept happens no earlier than 1 cycle later.
- Throughput: one word per WIDTH+3 cycles at best.
- Back-pressure: HOLD persists indefinitely, with `out_data` frozen.

## Structure
- Shared header `serial_xfer_defs.vh` holds:
  - state codes: IDLE=2'd0, CLEAR=2'd1, SHIFT=2'd2, HOLD=2'd3;
  - default WIDTH.
- Single FSM module. One sub-module is natural: `serial_bit_cnt`, a loadable up-counter with a terminal-count flag at WIDTH-1, reused by the sink-side collector.
- The bench instantiates the serial unit as the DUT's partner.

## Test plan
- Reset, then `in_data`=8'h01 → `unit_clr` pulses 1 cycle; `unit_x` sequence 1,0,0,0,0,0,0,0; `out_data`=8'hFF with `out_valid` 9 cycles after accept.
- Words 8'h00, 8'h80, 8'h34 back-to-back with `out_ready`=1 → 8'h00, 8'h80, 8'hCC, with no lost or duplicated words and `in_ready` low throughout each transfer.
- `out_ready`=0 for 5 cycles in HOLD → `out_valid` stays 1 and `out_data` stable; `in_data` 8'hAA offered meanwhile is not accepted until IDLE.
- Pulse `areset_n` low during SHIFT at bit 3 → all outputs at reset values immediately, `in_ready`=1. A following word 8'h01 returns 8'hFF correctly.
- `in_valid` pulse while `busy` → ignored, and the result is unaffected.
- WIDTH=4 instance, `in_data`=4'h6 → `out_data`=4'hA, 5 cycles after accept.
